mips_mc_ctrl: RTL

Multi-cycle main controller for the MIPS datapath. The datapath registers (PC, IR, MDR, A, B, ALUOut) are reset-initialised flip-flops; this block sequences their enables.
- A Moore FSM walks each instruction through fetch/decode/execute/memory/writeback.
- A handshake with unified instruction/data memory stalls the sequence on wait states.
- ALU function decode (funct field) stays outside in the existing ALU decoder; this block only issues aluop.

---
 rtl/mips_mc_ctrl_pkg.sv | 53 +++++
 rtl/mips_mc_outdec.sv | 66 ++++++
 rtl/mips_mc_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// states, opcodes, ALU/mux select codes and the Moore control bundle.
package mips_mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// Moore output decode: pure function of the current state.
// Mealy enables and reset gating live in the top level.
module mips_mc_outdec
  import mips_mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = SRCB_4;
        ctrl.aluop   = ALU_ADD;
        ctrl.pcsrc   = PC_ALU;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_BR;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_SUB;
        ctrl.pcsrc   = PC_ALUOUT;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc = PC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller: state register, next-state,
// memory-ready/zero qualified enables and reset output gating.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int SW  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           iord,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     aluop,
  output logic [1:0]     pcsrc,
  output logic           pcen,
  output logic           illegal,
  output logic [SW-1:0]  state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  logic op_lw;
  logic op_sw;
  logic op_r;
  logic op_beq;
  logic op_addi;
  logic op_j;
  logic op_ok;
  logic fetch_go;

  assign op_lw   = (op == OPW'(OP_LW));
  assign op_sw   = (op == OPW'(OP_SW));
  assign op_r    = (op == OPW'(OP_RTYPE));
  assign op_beq  = (op == OPW'(OP_BEQ));
  assign op_addi = (op == OPW'(OP_ADDI));
  assign op_j    = (op == OPW'(OP_J));
  assign op_ok   = op_lw | op_sw | op_r
                 | op_beq | op_addi | op_j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:
        state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          op_lw, op_sw: state_d = S_MEMADR;
          op_r:         state_d = S_EXEC;
          op_beq:       state_d = S_BRANCH;
          op_addi:      state_d = S_ADDIEX;
          op_j:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = op_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:
        state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mips_mc_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Only Mealy terms: fetch completion and branch taken.
  assign fetch_go = (state_q == S_FETCH) & mem_ready;

  assign irwrite  = rst_n & fetch_go;
  assign pcen     = rst_n & (fetch_go
                  | (state_q == S_JUMP)
                  | ((state_q == S_BRANCH) & zero));
  assign illegal  = rst_n & (state_q == S_DECODE) & ~op_ok;

  assign mem_req  = rst_n & ctrl.mem_req;
  assign iord     = rst_n & ctrl.iord;
  assign memwrite = rst_n & ctrl.memwrite;
  assign regdst   = rst_n & ctrl.regdst;
  assign memtoreg = rst_n & ctrl.memtoreg;
  assign regwrite = rst_n & ctrl.regwrite;
  assign alusrca  = rst_n & ctrl.alusrca;
  assign alusrcb  = {2{rst_n}} & ctrl.alusrcb;
  assign aluop    = {2{rst_n}} & ctrl.aluop;
  assign pcsrc    = {2{rst_n}} & ctrl.pcsrc;
  assign state    = rst_n ? SW'(state_q) : '0;

endmodule
